// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and sizing constants for multdiv_unit
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER = 32;
    localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one unsigned restoring-division iteration (shift, trial subtract, quotient bit)
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift the next dividend bit into the remainder and keep the difference only if it stays non-negative
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff = shifted - {1'b0, divisor};
        rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed Booth multiply and restoring divide; divider present only with MULTDIV_DIV_EN
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = MD_ITER
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(ITER + 1);

    state_t state, state_next, div_dest;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] acc, acc_next;
    logic [WIDTH:0] booth_hi, booth_sum, mcand_ext;
    logic [2*WIDTH-1:0] product;
    logic start_ok, running, last;
    logic [WIDTH-1:0] res_next;
    logic exc_next;

    assign start_ok = (state == IDLE || state == DONE) && (ctrl_MULT ^ ctrl_DIV);
    assign running = state == MUL || state == DIV;
    assign last = cnt == CW'(ITER - 1);

`ifdef MULTDIV_DIV_EN
    localparam logic [WIDTH-1:0] INT_MIN = WIDTH'(MD_INT_MIN);

    logic [WIDTH-1:0] rem, quo, dvs, rem_step, quo_step;
    logic neg, ovf;

    assign div_dest = data_operandB == '0 ? DONE : DIV;

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in (rem),
        .quo_in (quo),
        .divisor(dvs),
        .rem_out(rem_step),
        .quo_out(quo_step)
    );

    // Divider registers: load magnitudes and sign/overflow flags on start, then iterate while in DIV
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            neg <= 1'b0;
            ovf <= 1'b0;
        end else if (start_ok) begin
            rem <= '0;
            quo <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            dvs <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovf <= data_operandA == INT_MIN && data_operandB == '1;
        end else if (state == DIV) begin
            rem <= rem_step;
            quo <= quo_step;
        end
    end
`else
    assign div_dest = DONE;
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end

    // Next state: starts only from IDLE/DONE, DONE lasts one cycle, the last iteration enters DONE
    always_comb begin
        state_next = start_ok ? (ctrl_MULT ? MUL : div_dest) :
                     state == DONE ? IDLE :
                     running && last ? DONE : state;
    end

    // FSM outputs
    always_comb begin
        busy = running;
        data_resultRDY = state == DONE;
    end

    // Booth step: the upper half is summed one bit wider so INT_MIN multiplicands cannot overflow
    always_comb begin
        mcand_ext = {mcand[WIDTH-1], mcand};
        booth_hi = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        booth_sum = acc[1:0] == 2'b01 ? booth_hi + mcand_ext :
                    acc[1:0] == 2'b10 ? booth_hi - mcand_ext : booth_hi;
        acc_next = {booth_sum, acc[WIDTH:1]};
        product = acc_next[2*WIDTH:1];
    end

    // Multiplier registers and iteration counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            mcand <= '0;
            acc <= '0;
        end else if (start_ok) begin
            cnt <= '0;
            mcand <= data_operandA;
            acc <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        end else if (running) begin
            cnt <= cnt + CW'(1);
            if (state == MUL) acc <= acc_next;
        end
    end

    // Value captured on DONE entry; starts that jump straight to DONE report 0 with an exception
    always_comb begin
        res_next = '0;
        exc_next = 1'b1;
        if (state == MUL) begin
            res_next = product[WIDTH-1:0];
            exc_next = ~(&product[2*WIDTH-1:WIDTH-1] | ~|product[2*WIDTH-1:WIDTH-1]);
        end
`ifdef MULTDIV_DIV_EN
        if (state == DIV) begin
            res_next = neg ? -quo_step : quo_step;
            exc_next = ovf;
        end
`endif
    end

    // Result registers change only on entry to DONE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result <= '0;
            data_exception <= 1'b0;
        end else if (state_next == DONE) begin
            data_result <= res_next;
            data_exception <= exc_next;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: randomized and directed checks of multdiv_unit against an arithmetic reference model
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic ctrl_MULT = 1'b0;
    logic ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic data_exception, data_resultRDY, busy;
    int checks = 0;
    int errors = 0;

    multdiv_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint p;
        lat = 33;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = p != longint'($signed(p[31:0]));
        end
`ifdef MULTDIV_DIV_EN
        else if (b == 32'd0) begin
            r = '0;
            e = 1'b1;
            lat = 1;
        end else if (a == MD_INT_MIN && b == 32'hFFFF_FFFF) begin
            r = MD_INT_MIN;
            e = 1'b1;
        end else begin
            p = longint'($signed(a)) / longint'($signed(b));
            r = p[31:0];
            e = 1'b0;
        end
`else
        else begin
            r = '0;
            e = 1'b1;
            lat = 1;
        end
`endif
    endfunction

    // Called at posedge+1; starts an operation and waits (bounded) for RDY
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b, input int poke_at);
        logic [31:0] er;
        logic ee;
        int el;
        int n;
        model(is_div, a, b, er, ee, el);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = !is_div;
        ctrl_DIV = is_div;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        n = 1;
        if (el > 1) check("busy_after_start", busy, 1);
        while (!data_resultRDY && n < 40) begin
            if (n == poke_at) begin
                ctrl_DIV = 1'b1;
                data_operandA = '0;
                data_operandB = '0;
            end
            @(posedge clock);
            #1;
            ctrl_DIV = 1'b0;
            n++;
        end
        check("latency", n, el);
        check("result", data_result, er);
        check("exception", data_exception, ee);
        check("busy_at_rdy", busy, 0);
    endtask

    task automatic finish_op();
        @(posedge clock);
        #1;
        check("rdy_one_cycle", data_resultRDY, 0);
    endtask

    function automatic logic [31:0] pick();
        int sel;
        sel = $urandom_range(0, 5);
        return sel == 0 ? 32'd0 : sel == 1 ? 32'd1 : sel == 2 ? 32'hFFFF_FFFF :
               sel == 3 ? MD_INT_MIN : sel == 4 ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rdy_seen;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", data_result, 0);
        check("reset_exception", data_exception, 0);
        check("reset_rdy", data_resultRDY, 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op(0, 32'd7, -32'sd6, -1); finish_op();
        check("mul_7x-6", data_result, 32'hFFFF_FFD6);
        run_op(0, 32'h0001_0000, 32'h0001_0000, -1); finish_op();
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1); finish_op();
        run_op(1, -32'sd100, 32'd7, -1); finish_op();
        run_op(1, 32'd100, -32'sd7, -1); finish_op();
        run_op(1, 32'd5, 32'd0, -1); finish_op();
        run_op(1, MD_INT_MIN, 32'hFFFF_FFFF, -1); finish_op();

        run_op(0, 32'd7, -32'sd6, 5); finish_op();

        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("both_ctrl_busy", busy, 0);
            check("both_ctrl_rdy", data_resultRDY, 0);
        end
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;

        run_op(0, 32'd7, -32'sd6, -1);
        run_op(0, 32'd3, 32'd4, -1); finish_op();

        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_result", data_result, 0);
        check("rst_mid_exception", data_exception, 0);
        check("rst_mid_rdy", data_resultRDY, 0);
        check("rst_mid_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("rst_no_rdy", rdy_seen, 0);
        run_op(0, 32'd3, 32'd4, -1); finish_op();

        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 1)), pick(), pick(), -1);
            if ($urandom_range(0, 1) == 1) finish_op();
        end
        finish_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
